if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction queue between fetch and decode. Fetch pushes {pc, inst} pairs with a valid/ready handshake; decode pops the head when it is not stalled. Fetch can keep running while decode stalls, up to DEPTH instructions. A flush empties the queue in one cycle. Whenever the queue is empty, decode receives a zero bubble.

## Interface
Parameters:
- ADDR_WIDTH, default 32, width of pc.
- INST_WIDTH, default 32, width of instruction word.
- DEPTH, default 4, number of entries. Must be a power of two and ≥ 2.
- CNT_WIDTH, default $clog2(DEPTH+1), width of occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  6  pipeline stall vector; stall[1]=1 means decode holds its current instruction.
- flush_i  in  1  discard all queued entries (branch/jump redirect).
- if_valid_i  in  1  fetch presents a valid instruction this cycle.
- if_pc_i  in  ADDR_WIDTH  fetched pc.
- if_inst_i  in  INST_WIDTH  fetched instruction.
- if_ready_o  out  1  queue can accept a push this cycle.
- id_valid_o  out  1  head entry is valid.
- id_pc_o  out  ADDR_WIDTH  head pc; 0 when empty.
- id_inst_o  out  INST_WIDTH  head instruction; 0 when empty.
- count_o  out  CNT_WIDTH  current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH {pc, inst} entries.
- Pointers: head and tail, each log2(DEPTH) bits, wrap modulo DEPTH naturally.
- count register, CNT_WIDTH bits.
- push = if_valid_i & if_ready_o.
- if_ready_o = (count < DEPTH). It does not depend on pop in the same cycle, so there is no combinational path from stall to ready.
- pop = id_valid_o & ~stall[1].
- id_valid_o = (count != 0).
- id_pc_o / id_inst_o = entry at head when count != 0, else 0.
- Push writes the entry at tail, then tail ← tail+1.
- Pop advances head ← head+1.
- Count update:
  - push only: count+1.
  - pop only: count−1.
  - push and pop in the same cycle: count unchanged; both pointers advance. This is legal at any count from 1 to DEPTH−1.
- Full (count == DEPTH): if_ready_o = 0. if_valid_i is ignored, and fetch must hold its instruction.
- Empty (count == 0): no pop occurs regardless of stall[1]. Outputs are a zero bubble.
- Priority, highest first:
  1. rst: head = tail = count = 0. Storage contents need not be cleared.
  2. flush_i: head = tail = count = 0. A simultaneous push is dropped; a simultaneous pop is irrelevant.
  3. Normal push/pop.
- Reset or flush asserted while the queue is partially full discards every entry. There is no partial drain.
- Storage contents past the valid region are never observable, because outputs are gated by count.

## Timing
- Reset values: if_ready_o = 1, id_valid_o = 0, id_pc_o = 0, id_inst_o = 0, count_o = 0. All hold from the first edge with rst = 1.
- Latency: an instruction pushed at edge N is visible on id_* immediately after edge N if the queue was empty. This matches the one-cycle behaviour of the previous IF/ID register.
- An instruction queued behind k entries appears after k further pops.
- Outputs are functions of registered state only; there is no input-to-output combinational path.
- Flush at edge N: id_valid_o = 0 and id_* = 0 in the cycle after N. if_ready_o = 1 in the cycle after N.
- Sustained throughput is one instruction per cycle when stall[1] = 0 and fetch supplies every cycle.

## Test plan
- **Reset then single push.** Hold rst for 2 cycles, then push pc=0x0000_1000, inst=0x0010_0093 with stall=0.
  - During reset: all outputs 0 and if_ready_o = 1.
  - After the push edge: id_valid_o = 1 with that pc/inst.
  - Next edge: count returns to 0 and id_* = 0.
- **Fill under stall.** stall[1] = 1, push pc 0x1000, 0x1004, 0x1008, 0x100C (DEPTH = 4).
  - count_o = 4, if_ready_o = 0.
  - A fifth push of 0x1010 is ignored; id_pc_o stays 0x1000.
  - Release the stall: pcs come out 0x1000 → 0x100C on consecutive cycles.
- **Simultaneous push/pop with wrap-around.** Keep count = 2 and push + pop every cycle for 10 cycles with pcs incrementing by 4.
  - count_o stays 2 throughout.
  - Output pcs are in exact order, including across the pointer wrap.
- **Flush with push.** With count = 3, assert flush_i and if_valid_i together (pc 0x2000).
  - Next cycle: count_o = 0, id_valid_o = 0, id_* = 0.
  - 0x2000 is not queued.
- **Reset mid-operation.** With count = 2, assert rst for one cycle while pushing.
  - Next cycle: count_o = 0, outputs 0.
  - A subsequent push of pc 0x3000 appears at the head.
- **Empty with decode running.** count = 0, stall = 0, if_valid_i = 0 for 5 cycles.
  - id_valid_o = 0 and id_pc_o = id_inst_o = 0 throughout.
  - count_o never underflows; it stays 0.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry {pc, inst} queue between fetch and decode.
// Outputs come from registered state only; an empty queue presents a zero bubble.
module if_id_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush_i,
  input  logic                  if_valid_i,
  input  logic [ADDR_WIDTH-1:0] if_pc_i,
  input  logic [INST_WIDTH-1:0] if_inst_i,
  output logic                  if_ready_o,
  output logic                  id_valid_o,
  output logic [ADDR_WIDTH-1:0] id_pc_o,
  output logic [INST_WIDTH-1:0] id_inst_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] L_DEPTH = CNT_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
  logic [INST_WIDTH-1:0] r_inst [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_WIDTH-1:0]  r_count;

  logic w_valid;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_unused_stall;

  assign w_valid = (r_count != '0);
  // Ready ignores pop, so stall never reaches fetch combinationally.
  assign w_ready = (r_count < L_DEPTH);
  assign w_push  = if_valid_i & w_ready;
  assign w_pop   = w_valid & ~stall[1];
  assign w_unused_stall = ^{stall[5:2], stall[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + 1'b1;
      if (w_pop)
        r_head <= r_head + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push & ~rst & ~flush_i) begin
      r_pc[r_tail]   <= if_pc_i;
      r_inst[r_tail] <= if_inst_i;
    end
  end

  assign if_ready_o = w_ready;
  assign id_valid_o = w_valid;
  assign id_pc_o    = w_valid ? r_pc[r_head]   : '0;
  assign id_inst_o  = w_valid ? r_inst[r_head] : '0;
  assign count_o    = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed stimulus with a scoreboard queue of expected
// {pc, inst} entries; a negedge monitor checks the head and pops on decode.
module tb_if_id_queue;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    stall = '0;
  logic          flush_i = 1'b0;
  logic          if_valid_i = 1'b0;
  logic [AW-1:0] if_pc_i = '0;
  logic [IW-1:0] if_inst_i = '0;
  logic          if_ready_o;
  logic          id_valid_o;
  logic [AW-1:0] id_pc_o;
  logic [IW-1:0] id_inst_o;
  logic [CW-1:0] count_o;

  logic [AW+IW-1:0] sb [$];
  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  if_id_queue #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(D), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
    .if_inst_i(if_inst_i), .if_ready_o(if_ready_o),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare against the scoreboard head, then pop if decode takes it.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 64'(count_o), 64'(sb.size()));
      chk("ready", 64'(if_ready_o), 64'(sb.size() < D));
      if (sb.size() > 0) begin
        chk("valid", 64'(id_valid_o), 64'd1);
        chk("head_pc", 64'(id_pc_o), 64'(sb[0][AW+IW-1:IW]));
        chk("head_inst", 64'(id_inst_o), 64'(sb[0][IW-1:0]));
        if (!stall[1] && !flush_i && !rst)
          void'(sb.pop_front());
      end else begin
        chk("bubble_valid", 64'(id_valid_o), 64'd0);
        chk("bubble_pc", 64'(id_pc_o), 64'd0);
        chk("bubble_inst", 64'(id_inst_o), 64'd0);
      end
    end
  end

  // One cycle of stimulus; the expected entry is queued when the push lands.
  task automatic drive(input logic r, input logic f, input logic st,
                       input logic v, input logic [AW-1:0] pc,
                       input logic [IW-1:0] in);
    bit acc;
    rst = r;
    flush_i = f;
    stall = {4'b0, st, 1'b0};
    if_valid_i = v;
    if_pc_i = pc;
    if_inst_i = in;
    acc = v && (sb.size() < D) && !r && !f;
    @(posedge clk);
    if (r || f)
      sb.delete();
    else if (acc)
      sb.push_back({pc, in});
    mon_en = 1'b1;
    #1;
  endtask

  task automatic idle(input logic st, input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, st, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset then single push
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ready", 64'(if_ready_o), 64'd1);
    chk("rst_valid", 64'(id_valid_o), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0010_0093);
    chk("push_pc", 64'(id_pc_o), 64'h1000);
    chk("push_inst", 64'(id_inst_o), 64'h0010_0093);
    idle(1'b0, 1);
    chk("drain_count", 64'(count_o), 64'd0);
    chk("drain_pc", 64'(id_pc_o), 64'd0);

    // Fill under stall
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1000 + 32'(4 * i),
            32'h0000_0013 + 32'(i << 20));
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(if_ready_o), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1010, 32'hDEAD_0013);
    chk("full_hold_pc", 64'(id_pc_o), 64'h1000);
    chk("full_hold_cnt", 64'(count_o), 64'd4);
    idle(1'b0, 4);
    chk("fill_drained", 64'(count_o), 64'd0);

    // Simultaneous push/pop with wrap-around
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h4000, 32'h0040_0013);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h4004, 32'h0041_0013);
    for (int i = 2; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h4000 + 32'(4 * i),
            32'h0040_0013 + 32'(i << 16));
      chk("pp_count", 64'(count_o), 64'd2);
    end
    chk("pp_head", 64'(id_pc_o), 64'h4028);
    idle(1'b0, 2);

    // Flush with push
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h5000 + 32'(4 * i), 32'h0050_0013);
    chk("pre_flush_cnt", 64'(count_o), 64'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 32'h0020_0013);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(id_valid_o), 64'd0);
    chk("flush_pc", 64'(id_pc_o), 64'd0);
    chk("flush_ready", 64'(if_ready_o), 64'd1);
    idle(1'b0, 1);

    // Reset mid-operation
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h6000, 32'h0060_0013);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h6004, 32'h0061_0013);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h6008, 32'h0062_0013);
    chk("mrst_count", 64'(count_o), 64'd0);
    chk("mrst_inst", 64'(id_inst_o), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 32'h0030_0093);
    chk("mrst_push_pc", 64'(id_pc_o), 64'h3000);
    idle(1'b0, 1);

    // Empty with decode running
    for (int i = 0; i < 5; i++) begin
      idle(1'b0, 1);
      chk("empty_count", 64'(count_o), 64'd0);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
